// File: rtl/usb_pkg.sv
// Shared definitions for the USB receive packet path.
// Holds PID encodings, the packet-decoder FSM state type, CRC5/CRC16
// constants, the data-packet byte limit and the bitwise CRC helpers.
package usb_pkg;

  // PID[3:0] encodings
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_DATA2 = 4'h7;
  localparam logic [3:0] PID_MDATA = 4'hF;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;
  localparam logic [3:0] PID_NYET  = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOK1,
    ST_TOK2,
    ST_TOK_CHK,
    ST_DATA,
    ST_HSK_CHK,
    ST_DROP
  } state_t;

  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_POLY      = 5'h14;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  // 1024 payload bytes plus the two CRC16 bytes
  localparam logic [10:0] MAX_DATA_BYTES = 11'd1026;

  // CRC5 register over the 11 token bits {ENDP,ADDR}, LSB first
  function automatic logic [4:0] crc5_token(input logic [10:0] bits);
    logic [4:0] c;
    logic       fb;
    c = CRC5_INIT;
    for (int unsigned i = 0; i < 11; i++) begin
      fb = c[0] ^ bits[i];
      c  = c >> 1;
      if (fb) c = c ^ CRC5_POLY;
    end
    return c;
  endfunction

  // One byte of reflected CRC16, LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = c >> 1;
      if (fb) c = c ^ CRC16_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 register.
// Ports: clk; clear (synchronous, loads CRC16_INIT, has priority);
//        enable (fold data into the register); data (byte); crc (register).
// The parent drives clear during its reset, so no separate reset port.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge clk) begin
    if (clear) begin
      crc <= CRC16_INIT;
    end else if (enable) begin
      crc <= crc16_byte(crc, data);
    end
  end

endmodule

// File: rtl/usb_rx_packet.sv
// USB receive packet decoder sitting behind the ULPI byte stream.
// Ports: CLK_60M clock; NRST_A_USB synchronous active-low reset;
//        RX_DATA/RX_STRB/RX_END/RX_FAIL byte stream from the ULPI stage;
//        PID last accepted PID; TOKEN_VALID/TOKEN_ADDR/TOKEN_ENDP/FRAME_NUM
//        decoded tokens; HSK_VALID handshakes; DATA_O/DATA_STRB/DATA_END/
//        DATA_ERR payload stream with CRC16 removed; PKT_ERR any bad packet.
// All pulse outputs are registered and appear one cycle after the event.
module usb_rx_packet
  import usb_pkg::*;
(
  input  logic        CLK_60M,
  input  logic        NRST_A_USB,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_STRB,
  input  logic        RX_END,
  input  logic        RX_FAIL,
  output logic [3:0]  PID,
  output logic        TOKEN_VALID,
  output logic [6:0]  TOKEN_ADDR,
  output logic [3:0]  TOKEN_ENDP,
  output logic [10:0] FRAME_NUM,
  output logic        HSK_VALID,
  output logic [7:0]  DATA_O,
  output logic        DATA_STRB,
  output logic        DATA_END,
  output logic        DATA_ERR,
  output logic        PKT_ERR
);

  state_t      state, state_nx, pid_target;
  logic        end_pend;
  logic        fail_now, end_now, byte_take;
  logic        pid_ok, crc5_ok, data_ok, line_full;
  logic [10:0] cnt;
  logic        ovf;
  logic [7:0]  tok_b1, tok_b2;
  logic [7:0]  dly0, dly1;
  logic [15:0] crc16;
  logic        crc_clear, crc_en;
  logic        token_valid_nx, hsk_valid_nx, pkt_err_nx;
  logic        data_end_nx, data_err_nx, data_strb_nx;

  // A byte arriving together with RX_END is consumed this cycle and the
  // end is acted on next cycle, once the byte is in the CRC/delay line.
  assign fail_now  = RX_FAIL && (state != ST_IDLE);
  assign end_now   = (RX_END && !RX_STRB) || end_pend;
  assign byte_take = RX_STRB && !fail_now && !end_pend;

  assign pid_ok    = (RX_DATA[3:0] == ~RX_DATA[7:4]);
  assign crc5_ok   = (tok_b2[7:3] == ~crc5_token({tok_b2[2:0], tok_b1}));
  assign line_full = (cnt >= 11'd2);
  assign data_ok   = line_full && !ovf && (crc16 == CRC16_RESIDUAL);

  assign crc_clear = !NRST_A_USB || (state == ST_IDLE);
  assign crc_en    = (state == ST_DATA) && byte_take;

  usb_crc16 u_crc16 (
    .clk    (CLK_60M),
    .clear  (crc_clear),
    .enable (crc_en),
    .data   (RX_DATA),
    .crc    (crc16)
  );

  always_comb begin
    case (RX_DATA[3:0])
      PID_OUT, PID_IN, PID_SETUP, PID_SOF:       pid_target = ST_TOK1;
      PID_DATA0, PID_DATA1, PID_DATA2, PID_MDATA: pid_target = ST_DATA;
      PID_ACK, PID_NAK, PID_STALL, PID_NYET:     pid_target = ST_HSK_CHK;
      default:                                   pid_target = ST_DROP;
    endcase
  end

  // State register
  always_ff @(posedge CLK_60M) begin
    if (!NRST_A_USB) state <= ST_IDLE;
    else             state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (fail_now) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (byte_take) state_nx = pid_ok ? pid_target : ST_DROP;
        ST_TOK1: begin
          if (end_now)        state_nx = ST_IDLE;
          else if (byte_take) state_nx = ST_TOK2;
        end
        ST_TOK2: begin
          if (end_now)        state_nx = ST_IDLE;
          else if (byte_take) state_nx = ST_TOK_CHK;
        end
        ST_TOK_CHK, ST_HSK_CHK: begin
          if (end_now)        state_nx = ST_IDLE;
          else if (byte_take) state_nx = ST_DROP;
        end
        ST_DATA, ST_DROP: if (end_now) state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Output decode (registered below)
  always_comb begin
    token_valid_nx = 1'b0;
    hsk_valid_nx   = 1'b0;
    pkt_err_nx     = 1'b0;
    data_end_nx    = 1'b0;
    data_err_nx    = 1'b0;
    data_strb_nx   = (state == ST_DATA) && byte_take && line_full;
    if (fail_now) begin
      pkt_err_nx  = 1'b1;
      data_err_nx = (state == ST_DATA);
    end else if (end_now) begin
      case (state)
        ST_TOK1, ST_TOK2, ST_DROP: pkt_err_nx = 1'b1;
        ST_TOK_CHK: begin
          if (crc5_ok) token_valid_nx = 1'b1;
          else         pkt_err_nx     = 1'b1;
        end
        ST_HSK_CHK: hsk_valid_nx = 1'b1;
        ST_DATA: begin
          if (data_ok) begin
            data_end_nx = 1'b1;
          end else begin
            data_err_nx = 1'b1;
            pkt_err_nx  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK_60M) begin
    if (!NRST_A_USB) begin
      end_pend    <= 1'b0;
      cnt         <= '0;
      ovf         <= 1'b0;
      tok_b1      <= '0;
      tok_b2      <= '0;
      dly0        <= '0;
      dly1        <= '0;
      PID         <= '0;
      TOKEN_VALID <= 1'b0;
      TOKEN_ADDR  <= '0;
      TOKEN_ENDP  <= '0;
      FRAME_NUM   <= '0;
      HSK_VALID   <= 1'b0;
      DATA_O      <= '0;
      DATA_STRB   <= 1'b0;
      DATA_END    <= 1'b0;
      DATA_ERR    <= 1'b0;
      PKT_ERR     <= 1'b0;
    end else begin
      end_pend    <= byte_take && RX_END;
      TOKEN_VALID <= token_valid_nx;
      HSK_VALID   <= hsk_valid_nx;
      PKT_ERR     <= pkt_err_nx;
      DATA_END    <= data_end_nx;
      DATA_ERR    <= data_err_nx;
      DATA_STRB   <= data_strb_nx;

      if (state == ST_IDLE) begin
        cnt <= '0;
        ovf <= 1'b0;
        if (byte_take && pid_ok) PID <= RX_DATA[3:0];
      end

      if ((state == ST_TOK1) && byte_take) tok_b1 <= RX_DATA;
      if ((state == ST_TOK2) && byte_take) tok_b2 <= RX_DATA;

      // Two-deep delay line: a byte leaves only when a newer one arrives,
      // so the trailing CRC16 pair is never emitted.
      if ((state == ST_DATA) && byte_take) begin
        if (cnt == MAX_DATA_BYTES) ovf <= 1'b1;
        else                       cnt <= cnt + 11'd1;
        dly0 <= RX_DATA;
        dly1 <= dly0;
        if (line_full) DATA_O <= dly1;
      end

      if (token_valid_nx) begin
        TOKEN_ADDR <= tok_b1[6:0];
        TOKEN_ENDP <= {tok_b2[2:0], tok_b1[7]};
        if (PID == PID_SOF) FRAME_NUM <= {tok_b2[2:0], tok_b1};
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed bench for usb_rx_packet: tokens, handshakes, data packets,
// error paths, reset behaviour.
module tb_usb_rx_packet;

  logic        CLK_60M = 1'b0;
  logic        NRST_A_USB = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_STRB = 1'b0;
  logic        RX_END = 1'b0;
  logic        RX_FAIL = 1'b0;
  logic [3:0]  PID;
  logic        TOKEN_VALID;
  logic [6:0]  TOKEN_ADDR;
  logic [3:0]  TOKEN_ENDP;
  logic [10:0] FRAME_NUM;
  logic        HSK_VALID;
  logic [7:0]  DATA_O;
  logic        DATA_STRB;
  logic        DATA_END;
  logic        DATA_ERR;
  logic        PKT_ERR;

  usb_rx_packet dut (
    .CLK_60M     (CLK_60M),
    .NRST_A_USB  (NRST_A_USB),
    .RX_DATA     (RX_DATA),
    .RX_STRB     (RX_STRB),
    .RX_END      (RX_END),
    .RX_FAIL     (RX_FAIL),
    .PID         (PID),
    .TOKEN_VALID (TOKEN_VALID),
    .TOKEN_ADDR  (TOKEN_ADDR),
    .TOKEN_ENDP  (TOKEN_ENDP),
    .FRAME_NUM   (FRAME_NUM),
    .HSK_VALID   (HSK_VALID),
    .DATA_O      (DATA_O),
    .DATA_STRB   (DATA_STRB),
    .DATA_END    (DATA_END),
    .DATA_ERR    (DATA_ERR),
    .PKT_ERR     (PKT_ERR)
  );

  always #5 CLK_60M = ~CLK_60M;

  int checks = 0;
  int failures = 0;

  // Pulse counters and payload capture, sampled on the falling edge
  int n_tok = 0, n_hsk = 0, n_perr = 0, n_dend = 0, n_derr = 0;
  logic [7:0] rxq[$];
  always @(negedge CLK_60M) begin
    if (TOKEN_VALID) n_tok++;
    if (HSK_VALID)   n_hsk++;
    if (PKT_ERR)     n_perr++;
    if (DATA_END)    n_dend++;
    if (DATA_ERR)    n_derr++;
    if (DATA_STRB)   rxq.push_back(DATA_O);
  end

  int b_tok, b_hsk, b_perr, b_dend, b_derr, b_q;
  logic [4:0] p;

  task automatic snap();
    b_tok = n_tok; b_hsk = n_hsk; b_perr = n_perr;
    b_dend = n_dend; b_derr = n_derr; b_q = rxq.size();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK_60M);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    @(posedge CLK_60M); #1;
    RX_DATA = b; RX_STRB = 1'b1;
    @(posedge CLK_60M); #1;
    RX_STRB = 1'b0;
  endtask

  task automatic put_end(input logic [7:0] b);
    @(posedge CLK_60M); #1;
    RX_DATA = b; RX_STRB = 1'b1; RX_END = 1'b1;
    @(posedge CLK_60M); #1;
    RX_STRB = 1'b0; RX_END = 1'b0;
  endtask

  // Returns {TOKEN_VALID,HSK_VALID,PKT_ERR,DATA_END,DATA_ERR} just after
  // the edge that sampled RX_END
  task automatic end_pkt(output logic [4:0] pulses);
    @(posedge CLK_60M); #1;
    RX_END = 1'b1;
    @(posedge CLK_60M); #1;
    RX_END = 1'b0;
    pulses = {TOKEN_VALID, HSK_VALID, PKT_ERR, DATA_END, DATA_ERR};
  endtask

  task automatic fail_pkt(output logic [4:0] pulses);
    @(posedge CLK_60M); #1;
    RX_FAIL = 1'b1;
    @(posedge CLK_60M); #1;
    RX_FAIL = 1'b0;
    pulses = {TOKEN_VALID, HSK_VALID, PKT_ERR, DATA_END, DATA_ERR};
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    @(posedge CLK_60M); #1;
    NRST_A_USB = 1'b0;
    repeat (2) @(posedge CLK_60M);
    #1;
    outs = {PID, TOKEN_VALID, TOKEN_ADDR, TOKEN_ENDP, FRAME_NUM, HSK_VALID,
            DATA_O, DATA_STRB, DATA_END, DATA_ERR, PKT_ERR};
    checks++;
    if (outs !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    NRST_A_USB = 1'b1;
    idle(2);
  endtask

  task automatic test_token();
    // SETUP addr 0 endp 0
    snap(); put(8'h2D); put(8'h00); put(8'h10); end_pkt(p); idle(3);
    checks++; if (p !== 5'b10000) begin failures++; $display("FAIL setup_pulse: got %b expected 10000", p); end
    checks++; if (n_tok - b_tok !== 1) begin failures++; $display("FAIL setup_count: got %0d expected 1", n_tok - b_tok); end
    checks++; if (n_perr - b_perr !== 0) begin failures++; $display("FAIL setup_perr: got %0d expected 0", n_perr - b_perr); end
    checks++; if (PID !== 4'hD) begin failures++; $display("FAIL setup_pid: got %h expected d", PID); end
    checks++; if (TOKEN_ADDR !== 7'h00) begin failures++; $display("FAIL setup_addr: got %h expected 00", TOKEN_ADDR); end
    checks++; if (TOKEN_ENDP !== 4'h0) begin failures++; $display("FAIL setup_endp: got %h expected 0", TOKEN_ENDP); end
    // IN addr 3A endp 5, CRC5 0A
    snap(); put(8'h69); put(8'hBA); put(8'h52); end_pkt(p); idle(3);
    checks++; if (p !== 5'b10000) begin failures++; $display("FAIL in_pulse: got %b expected 10000", p); end
    checks++; if (PID !== 4'h9) begin failures++; $display("FAIL in_pid: got %h expected 9", PID); end
    checks++; if (TOKEN_ADDR !== 7'h3A) begin failures++; $display("FAIL in_addr: got %h expected 3a", TOKEN_ADDR); end
    checks++; if (TOKEN_ENDP !== 4'h5) begin failures++; $display("FAIL in_endp: got %h expected 5", TOKEN_ENDP); end
    // SOF with the same 11 bits: frame 2BA
    snap(); put(8'hA5); put(8'hBA); put(8'h52); end_pkt(p); idle(3);
    checks++; if (p !== 5'b10000) begin failures++; $display("FAIL sof_pulse: got %b expected 10000", p); end
    checks++; if (FRAME_NUM !== 11'h2BA) begin failures++; $display("FAIL sof_frame: got %h expected 2ba", FRAME_NUM); end
    // Corrupted CRC5 byte: error, token fields held
    snap(); put(8'h69); put(8'hBA); put(8'h53); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL badcrc5_pulse: got %b expected 00100", p); end
    checks++; if (n_tok - b_tok !== 0) begin failures++; $display("FAIL badcrc5_tok: got %0d expected 0", n_tok - b_tok); end
    checks++; if (TOKEN_ENDP !== 4'h5) begin failures++; $display("FAIL badcrc5_hold: got %h expected 5", TOKEN_ENDP); end
    // Too short and too long
    snap(); put(8'h2D); put(8'h00); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL short_tok: got %b expected 00100", p); end
    snap(); put(8'h2D); put(8'h00); put(8'h10); put(8'h00); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL long_tok: got %b expected 00100", p); end
    checks++; if (n_perr - b_perr !== 1) begin failures++; $display("FAIL long_tok_perr: got %0d expected 1", n_perr - b_perr); end
  endtask

  task automatic test_data();
    logic [7:0] pkt [11] = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    logic [7:0] v;
    for (int pass = 0; pass < 2; pass++) begin
      snap();
      for (int i = 0; i < 11; i++) put((pass == 1 && i == 10) ? 8'h95 : pkt[i]);
      end_pkt(p); idle(3);
      checks++;
      if (rxq.size() - b_q !== 8) begin failures++; $display("FAIL data%0d_strobes: got %0d expected 8", pass, rxq.size() - b_q); end
      for (int i = 0; i < 8; i++) begin
        v = (b_q + i < rxq.size()) ? rxq[b_q + i] : 8'hxx;
        checks++;
        if (v !== pkt[i + 1]) begin failures++; $display("FAIL data%0d_byte%0d: got %h expected %h", pass, i, v, pkt[i + 1]); end
      end
      if (pass == 0) begin
        checks++; if (p !== 5'b00010) begin failures++; $display("FAIL data_good_pulse: got %b expected 00010", p); end
        checks++; if (n_derr - b_derr !== 0) begin failures++; $display("FAIL data_good_derr: got %0d expected 0", n_derr - b_derr); end
        checks++; if (n_dend - b_dend !== 1) begin failures++; $display("FAIL data_good_dend: got %0d expected 1", n_dend - b_dend); end
      end else begin
        checks++; if (p !== 5'b00101) begin failures++; $display("FAIL data_bad_pulse: got %b expected 00101", p); end
        checks++; if (n_dend - b_dend !== 0) begin failures++; $display("FAIL data_bad_dend: got %0d expected 0", n_dend - b_dend); end
      end
    end
  endtask

  task automatic test_handshake();
    snap(); put(8'hD2); end_pkt(p); idle(3);
    checks++; if (p !== 5'b01000) begin failures++; $display("FAIL ack_pulse: got %b expected 01000", p); end
    checks++; if (n_hsk - b_hsk !== 1) begin failures++; $display("FAIL ack_count: got %0d expected 1", n_hsk - b_hsk); end
    checks++; if (PID !== 4'h2) begin failures++; $display("FAIL ack_pid: got %h expected 2", PID); end
    snap(); put(8'hD3); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL badpid_pulse: got %b expected 00100", p); end
    checks++; if (PID !== 4'h2) begin failures++; $display("FAIL badpid_hold: got %h expected 2", PID); end
    snap(); put(8'hD2); put(8'hD2); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL long_hsk: got %b expected 00100", p); end
  endtask

  task automatic test_zero_len_and_fail();
    snap(); put(8'hC3); put(8'h00); put(8'h00); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00010) begin failures++; $display("FAIL zlp_pulse: got %b expected 00010", p); end
    checks++; if (rxq.size() - b_q !== 0) begin failures++; $display("FAIL zlp_strobes: got %0d expected 0", rxq.size() - b_q); end
    snap(); put(8'hC3); put(8'h12); fail_pkt(p); idle(3);
    checks++; if (p !== 5'b00101) begin failures++; $display("FAIL rxfail_pulse: got %b expected 00101", p); end
    checks++; if (rxq.size() - b_q !== 0) begin failures++; $display("FAIL rxfail_strobes: got %0d expected 0", rxq.size() - b_q); end
    checks++; if (n_dend - b_dend !== 0) begin failures++; $display("FAIL rxfail_dend: got %0d expected 0", n_dend - b_dend); end
  endtask

  task automatic test_reset_mid();
    snap(); put(8'h2D); put(8'h00);
    @(posedge CLK_60M); #1; NRST_A_USB = 1'b0;
    @(posedge CLK_60M); #1; NRST_A_USB = 1'b1;
    put(8'h2D); put(8'h00); put(8'h10); end_pkt(p); idle(3);
    checks++; if (n_tok - b_tok !== 1) begin failures++; $display("FAIL rstmid_tok: got %0d expected 1", n_tok - b_tok); end
    checks++; if (n_perr - b_perr !== 0) begin failures++; $display("FAIL rstmid_perr: got %0d expected 0", n_perr - b_perr); end
  endtask

  task automatic test_edge_cases();
    // Byte and end in the same cycle
    snap(); put_end(8'hD2); idle(3);
    checks++; if (n_hsk - b_hsk !== 1) begin failures++; $display("FAIL sameclk_hsk: got %0d expected 1", n_hsk - b_hsk); end
    snap(); put(8'hC3); put(8'h00); put_end(8'h00); idle(3);
    checks++; if (n_dend - b_dend !== 1) begin failures++; $display("FAIL sameclk_dend: got %0d expected 1", n_dend - b_dend); end
    // END while idle does nothing
    snap(); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00000) begin failures++; $display("FAIL idle_end: got %b expected 00000", p); end
    checks++; if (n_perr - b_perr !== 0) begin failures++; $display("FAIL idle_end_perr: got %0d expected 0", n_perr - b_perr); end
    // Valid-check PID of an unsupported type is dropped
    snap(); put(8'h3C); put(8'h11); put(8'h22); end_pkt(p); idle(3);
    checks++; if (p !== 5'b00100) begin failures++; $display("FAIL drop_pulse: got %b expected 00100", p); end
    // Back to back: handshake directly after a token
    snap(); put(8'h2D); put(8'h00); put(8'h10); end_pkt(p); put(8'h5A); end_pkt(p); idle(3);
    checks++; if (n_tok - b_tok !== 1 || n_hsk - b_hsk !== 1) begin
      failures++; $display("FAIL b2b_counts: got tok=%0d hsk=%0d expected 1 1", n_tok - b_tok, n_hsk - b_hsk);
    end
    checks++; if (PID !== 4'hA) begin failures++; $display("FAIL b2b_pid: got %h expected a", PID); end
  endtask

  initial begin
    test_reset();
    test_token();
    test_data();
    test_handshake();
    test_zero_len_and_fail();
    test_reset_mid();
    test_edge_cases();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
